// File: rtl/connect_four_pkg.sv
// Shared Connect Four types: light colours, board size defaults and controller states.
package connect_four_pkg;

    localparam int unsigned DEFAULT_COLS = 7;
    localparam int unsigned DEFAULT_ROWS = 6;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PLACE,
        SWAP,
        DONE
    } ctrl_state_t;

    function automatic light_t other_player(input light_t c);
        return (c == RED) ? GREEN : RED;
    endfunction

endpackage

// File: rtl/column_height_counter.sv
// Saturating piece counter for one board column; full when it holds ROWS pieces.
module column_height_counter
    import connect_four_pkg::*;
#(
    parameter  int unsigned ROWS  = DEFAULT_ROWS,
    localparam int unsigned HGT_W = $clog2(ROWS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [HGT_W-1:0] height,
    output logic             full
);

    logic [HGT_W-1:0] r_height;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_height <= '0;
        end else if (inc && !full) begin
            r_height <= r_height + HGT_W'(1);
        end
    end

    assign height = r_height;
    assign full   = (r_height == HGT_W'(ROWS));

endmodule

// File: rtl/drop_turn_controller.sv
// Connect Four drop sequencer: resolves the landing row, strobes the light array
// once per legal drop and alternates the turn between red and green.
module drop_turn_controller
    import connect_four_pkg::*;
#(
    parameter  int unsigned COLS  = DEFAULT_COLS,
    parameter  int unsigned ROWS  = DEFAULT_ROWS,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned HGT_W = $clog2(ROWS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             drop_key,
    input  logic [COL_W-1:0] col_sel,
    input  logic             game_over,
    output logic             place_valid,
    output logic [COL_W-1:0] place_col,
    output logic [ROW_W-1:0] place_row,
    output logic [1:0]       place_color,
    output logic [1:0]       turn,
    output logic [COLS-1:0]  col_full,
    output logic             board_full,
    output logic             illegal,
    output logic             done
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [COL_W-1:0] r_col;
    light_t           r_turn;
    logic             r_place_valid;
    logic [COL_W-1:0] r_place_col;
    logic [ROW_W-1:0] r_place_row;
    light_t           r_place_color;
    logic             r_illegal;
    logic             r_done;

    logic [HGT_W-1:0] w_height [COLS];
    logic [COLS-1:0]  w_col_full;
    logic [COLS-1:0]  w_inc;
    logic             w_board_full;
    logic             w_col_ok;

    logic             w_place_valid_d;
    logic [COL_W-1:0] w_place_col_d;
    logic [ROW_W-1:0] w_place_row_d;
    light_t           w_place_color_d;
    logic             w_illegal_d;
    logic             w_done_d;
    light_t           w_turn_d;

    for (genvar c = 0; c < int'(COLS); c++) begin : g_col
        assign w_inc[c] = (r_state == PLACE) && (r_col == COL_W'(c));
        column_height_counter #(.ROWS(ROWS)) u_height (
            .clock  (clock),
            .reset  (reset),
            .inc    (w_inc[c]),
            .height (w_height[c]),
            .full   (w_col_full[c])
        );
    end

    assign w_board_full = &w_col_full;

    // Latched column is playable only if it exists on the board and still has room
    always_comb begin
        w_col_ok = 1'b0;
        if (32'(r_col) < COLS) begin
            w_col_ok = !w_col_full[r_col];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The cycle after an illegal pulse is still treated as busy so retries keep a 3-cycle spacing
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (drop_key && !r_illegal) w_state_next = CHECK;
            CHECK: begin
                if (game_over)     w_state_next = DONE;
                else if (!w_col_ok) w_state_next = IDLE;
                else               w_state_next = PLACE;
            end
            PLACE:   w_state_next = SWAP;
            SWAP:    w_state_next = (game_over || w_board_full) ? DONE : IDLE;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_place_valid_d = 1'b0;
        w_place_col_d   = '0;
        w_place_row_d   = '0;
        w_place_color_d = OFF;
        w_illegal_d     = 1'b0;
        w_done_d        = (w_state_next == DONE);
        w_turn_d        = r_turn;
        if (r_state == CHECK && w_state_next == PLACE) begin
            w_place_valid_d = 1'b1;
            w_place_col_d   = r_col;
            w_place_row_d   = ROW_W'(w_height[r_col]);
            w_place_color_d = r_turn;
        end
        if (r_state == CHECK && w_state_next == IDLE) begin
            w_illegal_d = 1'b1;
        end
        if (r_state == SWAP && w_state_next == IDLE) begin
            w_turn_d = other_player(r_turn);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_col         <= '0;
            r_turn        <= RED;
            r_place_valid <= 1'b0;
            r_place_col   <= '0;
            r_place_row   <= '0;
            r_place_color <= OFF;
            r_illegal     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (r_state == IDLE && w_state_next == CHECK) begin
                r_col <= col_sel;
            end
            r_turn        <= w_turn_d;
            r_place_valid <= w_place_valid_d;
            r_place_col   <= w_place_col_d;
            r_place_row   <= w_place_row_d;
            r_place_color <= w_place_color_d;
            r_illegal     <= w_illegal_d;
            r_done        <= w_done_d;
        end
    end

    assign place_valid = r_place_valid;
    assign place_col   = r_place_col;
    assign place_row   = r_place_row;
    assign place_color = r_place_color;
    assign turn        = r_turn;
    assign illegal     = r_illegal;
    assign done        = r_done;
    assign col_full    = w_col_full;
    assign board_full  = w_board_full;

endmodule
